// File: rtl/draw_scene_ctrl_if.sv
// Host/VGA-side bus of draw_scene_ctrl: redraw handshake plus the realigned plot stream.
interface draw_scene_ctrl_if;
   logic        start;
   logic        busy;
   logic        done;
   logic [8:0]  vga_x;
   logic [7:0]  vga_y;
   logic [11:0] vga_colour;
   logic        vga_plot;

   modport master (
      input  start,
      output busy, done, vga_x, vga_y, vga_colour, vga_plot
   );

   modport slave (
      output start,
      input  busy, done, vga_x, vga_y, vga_colour, vga_plot
   );
endinterface

// File: rtl/draw_scene_ctrl.sv
// Scene redraw sequencer (background, gold sprites, stone sprites) and plot realignment stage.
// Optional TRANSPARENT_KEY_EN: sprite pixels with colour 12'h000 are not plotted.
module draw_scene_ctrl #(
   parameter int BG_W      = 320,
   parameter int BG_H      = 240,
   parameter int NUM_GOLD  = 8,
   parameter int NUM_STONE = 8
) (
   input  logic              clk,
   input  logic              resetn,
   draw_scene_ctrl_if.master bus,
   input  logic [17:0]       background_cout,
   input  logic [8:0]        gold_pixel_cout,
   input  logic [8:0]        stone_pixel_cout,
   input  logic [7:0]        gold_count,
   input  logic [7:0]        stone_count,
   input  logic [8:0]        X_out_background,
   input  logic [8:0]        Y_out_background,
   input  logic [11:0]       Color_out_background,
   input  logic [8:0]        X_out_gold,
   input  logic [7:0]        Y_out_gold,
   input  logic [11:0]       Color_out_gold,
   input  logic [8:0]        X_out_stone,
   input  logic [7:0]        Y_out_stone,
   input  logic [11:0]       Color_out_stone,
   output logic              clear_scene,
   output logic [2:0]        bg_ctrl,
   output logic [4:0]        gold_ctrl,
   output logic [4:0]        stone_ctrl
);

   typedef enum logic [3:0] {
      S_IDLE, S_CLEAR, S_BG_RUN, S_BG_FLUSH,
      S_GOLD_LOAD, S_GOLD_RUN, S_GOLD_FLUSH, S_GOLD_NEXT,
      S_STONE_LOAD, S_STONE_RUN, S_STONE_FLUSH, S_STONE_NEXT,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      SEL_BG = 2'd0, SEL_GOLD = 2'd1, SEL_STONE = 2'd2, SEL_NONE = 2'd3
   } sel_t;

   // sprite ctrl words: {resetn_c, enable_c, load_xy, enable_xy_adder, enable_count}
   localparam logic [4:0]  SPR_IDLE = 5'b10000;
   localparam logic [4:0]  SPR_LOAD = 5'b00100;
   localparam logic [4:0]  SPR_RUN  = 5'b11010;
   localparam logic [4:0]  SPR_NEXT = 5'b10001;
   localparam logic [9:0]  BG_W_EXT   = 10'(BG_W);
   localparam logic [17:0] BG_LAST    = {1'b0, 8'(BG_H - 1), 9'(BG_W - 1)};
   localparam logic [8:0]  PIX_LAST   = 9'd255;
   localparam logic [7:0]  GOLD_LAST  = 8'(NUM_GOLD - 1);
   localparam logic [7:0]  STONE_LAST = 8'(NUM_STONE - 1);

   state_t      state, state_n;
   logic        flush_last;
   logic        issue_valid, valid_d1, valid_d2;
   sel_t        issue_sel, sel_d1, sel_d2;
   logic [11:0] colour_mux;
   logic        unused_y_msb;

   assign unused_y_msb = Y_out_background[8];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= S_IDLE;
         flush_last <= 1'b0;
         valid_d1   <= 1'b0;
         valid_d2   <= 1'b0;
         sel_d1     <= SEL_NONE;
         sel_d2     <= SEL_NONE;
         bus.vga_x  <= '0;
         bus.vga_y  <= '0;
      end else begin
         state      <= state_n;
         flush_last <= (state == S_BG_FLUSH || state == S_GOLD_FLUSH ||
                        state == S_STONE_FLUSH) && !flush_last;
         valid_d1   <= issue_valid;
         valid_d2   <= valid_d1;
         sel_d1     <= issue_sel;
         sel_d2     <= sel_d1;
         // datapath X/Y already carry one register; this is the second stage
         case (sel_d1)
            SEL_BG: begin
               bus.vga_x <= X_out_background;
               bus.vga_y <= Y_out_background[7:0];
            end
            SEL_GOLD: begin
               bus.vga_x <= X_out_gold;
               bus.vga_y <= Y_out_gold;
            end
            SEL_STONE: begin
               bus.vga_x <= X_out_stone;
               bus.vga_y <= Y_out_stone;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_n     = state;
      clear_scene = 1'b1;
      bg_ctrl     = '0;
      gold_ctrl   = SPR_IDLE;
      stone_ctrl  = SPR_IDLE;
      issue_valid = 1'b0;
      issue_sel   = SEL_NONE;
      bus.done    = 1'b0;
      unique case (state)
         S_IDLE:       if (bus.start) state_n = S_CLEAR;
         S_CLEAR: begin
            clear_scene = 1'b0;
            state_n     = S_BG_RUN;
         end
         S_BG_RUN: begin
            bg_ctrl     = '1;
            issue_valid = {1'b0, background_cout[8:0]} < BG_W_EXT;
            issue_sel   = SEL_BG;
            if (background_cout == BG_LAST) state_n = S_BG_FLUSH;
         end
         S_BG_FLUSH:   if (flush_last) state_n = S_GOLD_LOAD;
         S_GOLD_LOAD: begin
            gold_ctrl = SPR_LOAD;
            state_n   = S_GOLD_RUN;
         end
         S_GOLD_RUN: begin
            gold_ctrl   = SPR_RUN;
            issue_valid = 1'b1;
            issue_sel   = SEL_GOLD;
            if (gold_pixel_cout == PIX_LAST) state_n = S_GOLD_FLUSH;
         end
         S_GOLD_FLUSH: if (flush_last) state_n = S_GOLD_NEXT;
         S_GOLD_NEXT: begin
            gold_ctrl = SPR_NEXT;
            state_n   = (gold_count == GOLD_LAST) ? S_STONE_LOAD : S_GOLD_LOAD;
         end
         S_STONE_LOAD: begin
            stone_ctrl = SPR_LOAD;
            state_n    = S_STONE_RUN;
         end
         S_STONE_RUN: begin
            stone_ctrl  = SPR_RUN;
            issue_valid = 1'b1;
            issue_sel   = SEL_STONE;
            if (stone_pixel_cout == PIX_LAST) state_n = S_STONE_FLUSH;
         end
         S_STONE_FLUSH: if (flush_last) state_n = S_STONE_NEXT;
         S_STONE_NEXT: begin
            stone_ctrl = SPR_NEXT;
            state_n    = (stone_count == STONE_LAST) ? S_DONE : S_STONE_LOAD;
         end
         S_DONE: begin
            bus.done = 1'b1;
            state_n  = S_IDLE;
         end
         default:      state_n = S_IDLE;
      endcase
   end

   always_comb begin
      colour_mux = '0;
      case (sel_d2)
         SEL_BG:    colour_mux = Color_out_background;
         SEL_GOLD:  colour_mux = Color_out_gold;
         SEL_STONE: colour_mux = Color_out_stone;
         default:   colour_mux = '0;
      endcase
   end

   assign bus.busy       = (state != S_IDLE);
   assign bus.vga_colour = colour_mux;
`ifdef TRANSPARENT_KEY_EN
   assign bus.vga_plot   = valid_d2 && !(sel_d2 != SEL_BG && colour_mux == 12'h000);
`else
   assign bus.vga_plot   = valid_d2;
`endif

endmodule

// File: tb/tb_draw_scene_ctrl.sv
// Directed bench for draw_scene_ctrl with behavioural background/gold/stone datapath models.
`timescale 1ns/1ps
module tb_draw_scene_ctrl;
   localparam int BG_W = 4, BG_H = 2, NUM_GOLD = 1, NUM_STONE = 1;
   localparam logic [8:0] GX = 9'd100, SX = 9'd200;
   localparam logic [7:0] GY = 8'd50,  SY = 8'd150;
`ifdef TRANSPARENT_KEY_EN
   localparam int EXP_GOLD = 216;
   localparam logic [8:0] EXP_FIRST_GX = 9'd108;
   localparam logic [7:0] EXP_FIRST_GY = 8'd52;
`else
   localparam int EXP_GOLD = 256;
   localparam logic [8:0] EXP_FIRST_GX = 9'd100;
   localparam logic [7:0] EXP_FIRST_GY = 8'd50;
`endif

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   draw_scene_ctrl_if bus ();

   logic [17:0] background_cout;
   logic [8:0]  gold_pixel_cout, stone_pixel_cout;
   logic [7:0]  gold_count, stone_count;
   logic [8:0]  X_out_background, Y_out_background, X_out_gold, X_out_stone;
   logic [7:0]  Y_out_gold, Y_out_stone;
   logic [11:0] Color_out_background, Color_out_gold, Color_out_stone;
   logic [11:0] bg_rom_q, gold_rom_q, stone_rom_q;
   logic        clear_scene;
   logic [2:0]  bg_ctrl;
   logic [4:0]  gold_ctrl, stone_ctrl;

   draw_scene_ctrl #(.BG_W(BG_W), .BG_H(BG_H), .NUM_GOLD(NUM_GOLD), .NUM_STONE(NUM_STONE)) dut (
      .clk(clk), .resetn(resetn), .bus(bus),
      .background_cout(background_cout),
      .gold_pixel_cout(gold_pixel_cout), .stone_pixel_cout(stone_pixel_cout),
      .gold_count(gold_count), .stone_count(stone_count),
      .X_out_background(X_out_background), .Y_out_background(Y_out_background),
      .Color_out_background(Color_out_background),
      .X_out_gold(X_out_gold), .Y_out_gold(Y_out_gold), .Color_out_gold(Color_out_gold),
      .X_out_stone(X_out_stone), .Y_out_stone(Y_out_stone), .Color_out_stone(Color_out_stone),
      .clear_scene(clear_scene), .bg_ctrl(bg_ctrl), .gold_ctrl(gold_ctrl), .stone_ctrl(stone_ctrl)
   );

   function automatic logic [11:0] bg_rom(input logic [17:0] a);
      return {2'b01, a[9], a[8:0]};
   endfunction
   function automatic logic [11:0] gold_rom(input logic [8:0] n);
      return (n < 9'd40) ? 12'h000 : {4'hA, n[7:0]};
   endfunction
   function automatic logic [11:0] stone_rom(input logic [8:0] n);
      return {4'h5, n[7:0]};
   endfunction
   function automatic logic [8:0] sprite_idx(input logic [8:0] x, input logic [7:0] y,
                                             input logic [8:0] x0, input logic [7:0] y0);
      logic [8:0] dx;
      logic [7:0] dy;
      dx = x - x0;
      dy = y - y0;
      return {1'b0, dy[3:0], dx[3:0]};
   endfunction

   // datapath models: counters, one X/Y register, two-stage ROM+colour register
   always @(posedge clk) begin
      if (!resetn || !clear_scene) background_cout <= '0;
      else if (bg_ctrl[2]) background_cout <= background_cout + 18'd1;
      X_out_background     <= background_cout[8:0];
      Y_out_background     <= background_cout[17:9];
      bg_rom_q             <= bg_rom(background_cout);
      Color_out_background <= bg_rom_q;

      if (!resetn || !gold_ctrl[4]) gold_pixel_cout <= '0;
      else if (gold_ctrl[3]) gold_pixel_cout <= gold_pixel_cout + 9'd1;
      if (!resetn || !clear_scene) gold_count <= '0;
      else if (gold_ctrl[0]) gold_count <= gold_count + 8'd1;
      X_out_gold     <= GX + {5'd0, gold_pixel_cout[3:0]};
      Y_out_gold     <= GY + {4'd0, gold_pixel_cout[7:4]};
      gold_rom_q     <= gold_rom(gold_pixel_cout);
      Color_out_gold <= gold_rom_q;

      if (!resetn || !stone_ctrl[4]) stone_pixel_cout <= '0;
      else if (stone_ctrl[3]) stone_pixel_cout <= stone_pixel_cout + 9'd1;
      if (!resetn || !clear_scene) stone_count <= '0;
      else if (stone_ctrl[0]) stone_count <= stone_count + 8'd1;
      X_out_stone     <= SX + {5'd0, stone_pixel_cout[3:0]};
      Y_out_stone     <= SY + {4'd0, stone_pixel_cout[7:4]};
      stone_rom_q     <= stone_rom(stone_pixel_cout);
      Color_out_stone <= stone_rom_q;
   end

   // plot monitor: classifies plots by screen region and accumulates anomalies
   int plots_bg = 0, plots_gold = 0, plots_stone = 0;
   int bg_bad = 0, gold_bad = 0, stone_bad = 0, align_bad = 0;
   int last_cls = 0;
   logic [8:0] first_gx = '0, last_gx = '0;
   logic [7:0] first_gy = '0, last_gy = '0;
   logic [9:0] g_hist1 = '0, g_hist2 = '0;
   logic       exp_plot;

   always @(negedge clk) begin
      g_hist1 <= {gold_ctrl[3], gold_pixel_cout};
      g_hist2 <= g_hist1;
      if (g_hist2[9]) begin
`ifdef TRANSPARENT_KEY_EN
         exp_plot = (gold_rom(g_hist2[8:0]) != 12'h000);
`else
         exp_plot = 1'b1;
`endif
         if (bus.vga_x !== GX + {5'd0, g_hist2[3:0]} || bus.vga_y !== GY + {4'd0, g_hist2[7:4]} ||
             bus.vga_plot !== exp_plot)
            align_bad <= align_bad + 1;
      end
      if (bus.vga_plot === 1'b1) begin
         if (bus.vga_x < GX) begin
            plots_bg <= plots_bg + 1;
            if (bus.vga_x >= 9'(BG_W) || bus.vga_y >= 8'(BG_H) ||
                bus.vga_colour !== bg_rom({1'b0, bus.vga_y, bus.vga_x}))
               bg_bad <= bg_bad + 1;
            last_cls <= 0;
         end else if (bus.vga_x < SX) begin
            plots_gold <= plots_gold + 1;
            if (bus.vga_colour !== gold_rom(sprite_idx(bus.vga_x, bus.vga_y, GX, GY)))
               gold_bad <= gold_bad + 1;
            if (last_cls != 1) begin
               first_gx <= bus.vga_x;
               first_gy <= bus.vga_y;
            end
            last_gx  <= bus.vga_x;
            last_gy  <= bus.vga_y;
            last_cls <= 1;
         end else begin
            plots_stone <= plots_stone + 1;
            if (bus.vga_colour !== stone_rom(sprite_idx(bus.vga_x, bus.vga_y, SX, SY)))
               stone_bad <= stone_bad + 1;
            last_cls <= 2;
         end
      end
   end

   int n_checks = 0;
   int n_fail = 0;

   task automatic test_reset();
      resetn = 1'b0;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
      n_checks++; if (bus.vga_plot !== 1'b0) begin n_fail++; $display("FAIL reset_plot: got %b want 0", bus.vga_plot); end
      n_checks++; if (bus.vga_x !== 9'd0 || bus.vga_y !== 8'd0) begin n_fail++; $display("FAIL reset_xy: got %0d,%0d want 0,0", bus.vga_x, bus.vga_y); end
      n_checks++; if (clear_scene !== 1'b1) begin n_fail++; $display("FAIL reset_clear: got %b want 1", clear_scene); end
      n_checks++; if (bg_ctrl !== 3'b000) begin n_fail++; $display("FAIL reset_bg_ctrl: got %b want 000", bg_ctrl); end
      n_checks++; if (gold_ctrl !== 5'b10000 || stone_ctrl !== 5'b10000) begin n_fail++; $display("FAIL reset_spr_ctrl: got %b/%b want 10000/10000", gold_ctrl, stone_ctrl); end
      resetn = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
   endtask

   task automatic test_full_scene();
      int n, done_at, busy_cyc, pb, pg, ps, bb, gb, sb, ab;
      pb = plots_bg; pg = plots_gold; ps = plots_stone;
      bb = bg_bad; gb = gold_bad; sb = stone_bad; ab = align_bad;
      n = 0; done_at = -1; busy_cyc = 0;
      bus.start = 1'b1;
      while (done_at < 0 && n < 3000) begin
         @(posedge clk); #1;
         n++;
         bus.start = 1'b0;
         if (bus.busy === 1'b1) busy_cyc++;
         if (bus.done === 1'b1) done_at = n;
      end
      n_checks++; if (done_at != 1040) begin n_fail++; $display("FAIL scene_latency: done at %0d want 1040", done_at); end
      n_checks++; if (busy_cyc != 1040) begin n_fail++; $display("FAIL scene_busy: %0d busy cycles want 1040", busy_cyc); end
      n_checks++; if (plots_bg - pb != 8) begin n_fail++; $display("FAIL bg_plots: got %0d want 8", plots_bg - pb); end
      n_checks++; if (bg_bad - bb != 0) begin n_fail++; $display("FAIL bg_pixels: %0d bad want 0", bg_bad - bb); end
      n_checks++; if (plots_gold - pg != EXP_GOLD) begin n_fail++; $display("FAIL gold_plots: got %0d want %0d", plots_gold - pg, EXP_GOLD); end
      n_checks++; if (gold_bad - gb != 0) begin n_fail++; $display("FAIL gold_colour: %0d bad want 0", gold_bad - gb); end
      n_checks++; if (align_bad - ab != 0) begin n_fail++; $display("FAIL gold_align: %0d bad want 0", align_bad - ab); end
      n_checks++; if (first_gx !== EXP_FIRST_GX || first_gy !== EXP_FIRST_GY) begin n_fail++; $display("FAIL gold_first: got %0d,%0d want %0d,%0d", first_gx, first_gy, EXP_FIRST_GX, EXP_FIRST_GY); end
      n_checks++; if (last_gx !== 9'd115 || last_gy !== 8'd65) begin n_fail++; $display("FAIL gold_last: got %0d,%0d want 115,65", last_gx, last_gy); end
      n_checks++; if (plots_stone - ps != 256) begin n_fail++; $display("FAIL stone_plots: got %0d want 256", plots_stone - ps); end
      n_checks++; if (stone_bad - sb != 0) begin n_fail++; $display("FAIL stone_colour: %0d bad want 0", stone_bad - sb); end
      @(posedge clk); #1;
      n_checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL done_pulse: done=%b busy=%b want 0/0", bus.done, bus.busy); end
   endtask

   task automatic test_reset_mid_gold();
      int n, tot, ok;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n = 0;
      while (gold_ctrl[3] !== 1'b1 && n < 2000) begin @(posedge clk); #1; n++; end
      n_checks++; if (gold_ctrl[3] !== 1'b1) begin n_fail++; $display("FAIL reach_gold_run: gold_ctrl=%b want x1xxx", gold_ctrl); end
      repeat (20) @(posedge clk);
      #1;
      resetn = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
      n_checks++; if (bus.vga_plot !== 1'b0) begin n_fail++; $display("FAIL midrst_plot: got %b want 0", bus.vga_plot); end
      resetn = 1'b1;
      tot = plots_bg + plots_gold + plots_stone;
      repeat (5) @(posedge clk);
      #1;
      n_checks++; if (plots_bg + plots_gold + plots_stone != tot) begin n_fail++; $display("FAIL midrst_noplot: %0d plots want 0", plots_bg + plots_gold + plots_stone - tot); end
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n_checks++; if (clear_scene !== 1'b0) begin n_fail++; $display("FAIL restart_clear: got %b want 0", clear_scene); end
      n = 1; ok = 0;
      while (!ok && n < 3000) begin @(posedge clk); #1; n++; if (bus.done === 1'b1) ok = n; end
      n_checks++; if (ok != 1040) begin n_fail++; $display("FAIL restart_latency: done at %0d want 1040", ok); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int n, d1, d2, ndone;
      bool_idle: begin end
      n = 0; d1 = -1; d2 = -1; ndone = 0;
      bus.start = 1'b1;
      while (d2 < 0 && n < 5000) begin
         @(posedge clk); #1;
         n++;
         if (bus.done === 1'b1) begin
            ndone++;
            if (d1 < 0) d1 = n; else d2 = n;
         end
         if (d1 > 0 && n == d1 + 1) begin
            n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: busy=%b want 0", bus.busy); end
         end
         if (d1 > 0 && n == d1 + 2) begin
            n_checks++; if (clear_scene !== 1'b0) begin n_fail++; $display("FAIL b2b_restart: clear_scene=%b want 0", clear_scene); end
         end
      end
      bus.start = 1'b0;
      n_checks++; if (d1 != 1040) begin n_fail++; $display("FAIL b2b_first: done at %0d want 1040", d1); end
      n_checks++; if (d2 != 2081) begin n_fail++; $display("FAIL b2b_second: done at %0d want 2081", d2); end
      n_checks++; if (ndone != 2) begin n_fail++; $display("FAIL b2b_count: %0d done pulses want 2", ndone); end
      @(posedge clk); #1;
   endtask

   initial begin
      bus.start = 1'b0;
      test_reset();
      test_full_scene();
      test_reset_mid_gold();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
